seq_det_scheduler: RTL
======================

Name: seq_det_scheduler

Overview:
- Shares one serial Moore sequence detector between NREQ requesters.
- Each requester submits a WORD_W-bit pattern word. The block arbitrates round-robin and clears the detector.
- It then shifts the word into the detector MSB-first and counts the cycles where the detector output is high.
- It reports the count and the requester ID. Sits between the requester logic and the detector instance in the lab top level.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WORD_W, 16, bits per job word (4..32)
- CNT_W, 5, width of match count; saturating
- DET_LAT, 1, cycles from det_x sampled to the corresponding det_y valid (1..3)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester job request; held high until gnt
- req_word  in  NREQ*WORD_W  job words; requester i at bits [i*WORD_W +: WORD_W]
- gnt  out  NREQ  one-hot, one-cycle accept pulse
- det_rst_n  out  1  active-low clear to detector
- det_x  out  1  serial bit to detector X
- det_y  in  1  detector Y
- done  out  1  one-cycle job-complete pulse
- done_id  out  $clog2(NREQ)  requester index of completed job; valid with done
- done_count  out  CNT_W  number of det_y-high samples in the job window; valid with done

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, rr pointer=0, gnt=0, det_x=0, det_rst_n=0, done=0, done_id=0, done_count=0. Reset mid-job abandons the job with no done pulse.
- FSM states: IDLE -> FLUSH -> SHIFT -> DRAIN -> REPORT -> IDLE.
- IDLE:
  - det_rst_n=1, det_x=0.
  - If any req is high, grant the first requester at or after the pointer, wrapping.
  - On grant: gnt[i]=1 for this cycle; latch req_word slice i and i; pointer <= (i+1) mod NREQ. Next state is FLUSH.
  - No req: stay in IDLE and keep the pointer.
- FLUSH: 1 cycle; det_rst_n=0, det_x=0, count cleared.
- SHIFT: WORD_W cycles; k=0..WORD_W-1; det_x = word[WORD_W-1-k]; det_rst_n=1.
- DRAIN: DET_LAT cycles; det_x=0.
- Counting:
  - det_y is sampled in SHIFT cycles k >= DET_LAT and in all DRAIN cycles, i.e. exactly WORD_W samples, each aligned to one shifted bit.
  - det_y is ignored in IDLE, FLUSH and the first DET_LAT SHIFT cycles.
  - Count increments on a high sample and saturates at 2^CNT_W-1.
- REPORT: 1 cycle; done=1, done_id/done_count registered and held until the next REPORT. Next state is IDLE.
- Latency: with gnt at cycle 0, done is at cycle WORD_W+DET_LAT+2. Minimum job-to-job period is WORD_W+DET_LAT+3 cycles.
- The word is latched at grant. Changes to req or req_word after grant do not affect the running job. req dropping after grant is legal.
- Requests arriving during a job wait; they are arbitrated in the IDLE cycle after REPORT.
- Simultaneous requests resolve strictly by the rotating pointer.
- gnt is one-hot or zero, and is only ever nonzero in IDLE.

Optional Feature:
- Macro SEQ_DET_SCHED_FIRSTHIT_EN.
- Defined:
  - Adds output done_first, width $clog2(WORD_W)+1, valid with done.
  - done_first = index k of the first shifted bit whose aligned det_y sample was high, or WORD_W if none. It is not affected by count saturation.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Bench detector model asserts Y when the last two X bits are 1, with DET_LAT=1. Single req[0], word 16'hF000 -> gnt[0] at cycle 0, done at cycle 19, done_id=0, done_count=3, done_first=1 (if enabled).
- req=4'b1111 held continuously with pointer=0 -> grant order 0,1,2,3,0. Each gnt is exactly 20 cycles after the previous one.
- req[2] only with word 16'hFFFF and CNT_W=3 -> done_count saturates at 7; done_first=1.
- Word 16'hAAAA -> done_count=0, done_first=16. det_rst_n is low for exactly 1 cycle, the cycle after gnt.
- Drop rst_n for 1 cycle mid-SHIFT -> no done. After release: gnt=0 and det_rst_n=0 during reset; next grant goes to the lowest requesting index (pointer=0).
- req[1] deasserted and req_word changed the cycle after gnt -> result still reflects the latched word; no second gnt to requester 1.

Source files
------------

// File: rtl/seq_det_scheduler_if.sv
// rtl/seq_det_scheduler_if.sv - requester-side job/result bundle for seq_det_scheduler
// done_first exists only when SEQ_DET_SCHED_FIRSTHIT_EN is defined.
interface seq_det_scheduler_if #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] req_word;
  logic [NREQ-1:0]        gnt;
  logic                   done;
  logic [IDW-1:0]         done_id;
  logic [CNT_W-1:0]       done_count;

`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
  logic [$clog2(WORD_W):0] done_first;

  modport master (output req, req_word, input gnt, done, done_id, done_count, done_first);
  modport slave  (input req, req_word, output gnt, done, done_id, done_count, done_first);
`else
  modport master (output req, req_word, input gnt, done, done_id, done_count);
  modport slave  (input req, req_word, output gnt, done, done_id, done_count);
`endif
endinterface

// File: rtl/seq_det_scheduler.sv
// rtl/seq_det_scheduler.sv - round-robin job scheduler sharing one serial Moore sequence detector
// Optional first-hit index on done_first: define SEQ_DET_SCHED_FIRSTHIT_EN.
module seq_det_scheduler #(
  parameter int NREQ    = 4,
  parameter int WORD_W  = 16,
  parameter int CNT_W   = 5,
  parameter int DET_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_det_scheduler_if.slave rq,
  output logic               det_rst_n,
  output logic               det_x,
  input  logic               det_y
);
  localparam int IDW = $clog2(NREQ);
  localparam int IW1 = IDW + 1;
  localparam int STW = $clog2(WORD_W + DET_LAT + 1);
  localparam int FW  = $clog2(WORD_W) + 1;
  localparam logic [STW-1:0] SHIFT_LAST = STW'(WORD_W - 1);
  localparam logic [STW-1:0] STEP_LAST  = STW'(WORD_W + DET_LAT - 1);
  localparam logic [STW-1:0] LAT        = STW'(DET_LAT);

  typedef enum logic [2:0] {IDLE, FLUSH, SHIFT, DRAIN, REPORT} state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    res_id_q, res_id_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [STW-1:0]    step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0]  cnt_next;
  logic              sample;
  logic              found;
  logic [IDW-1:0]    pick;
  logic [IW1-1:0]    cand;
  logic [IDW-1:0]    cand_idx;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
  logic [FW-1:0]     first_q, first_d;
  logic [FW-1:0]     res_first_q, res_first_d;
  logic [FW-1:0]     first_next;
`endif

  // First requester at or after the rotating pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = ptr_q;
    cand     = '0;
    cand_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = {1'b0, ptr_q} + IW1'(j);
      if (cand >= IW1'(NREQ)) cand = cand - IW1'(NREQ);
      cand_idx = cand[IDW-1:0];
      if (!found && rq.req[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // det_y for shifted bit k arrives DET_LAT cycles later, so sampling starts at step DET_LAT.
  always_comb begin
    sample   = det_y && (state_q == SHIFT || state_q == DRAIN) && (step_q >= LAT);
    cnt_next = (sample && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
    first_next = (sample && first_q == FW'(WORD_W)) ? FW'(step_q - LAT) : first_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = 1'b1;
    ptr_d     = ptr_q;
    id_d      = id_q;
    word_d    = word_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    res_id_d  = res_id_q;
    res_cnt_d = res_cnt_q;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
    first_d     = first_q;
    res_first_d = res_first_q;
`endif
    rq.gnt    = '0;
    rq.done   = 1'b0;
    det_rst_n = armed_q;
    det_x     = 1'b0;
    case (state_q)
      IDLE: begin
        // armed_q keeps gnt quiet while rst_n is low even though the state reads IDLE.
        if (armed_q && found) begin
          rq.gnt[pick] = 1'b1;
          id_d         = pick;
          word_d       = rq.req_word[pick*WORD_W +: WORD_W];
          ptr_d        = (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
          state_d      = FLUSH;
        end
      end
      FLUSH: begin
        det_rst_n = 1'b0;
        cnt_d     = '0;
        step_d    = '0;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
        first_d   = FW'(WORD_W);
`endif
        state_d   = SHIFT;
      end
      SHIFT: begin
        det_x  = word_q[WORD_W-1];
        word_d = word_q << 1;
        cnt_d  = cnt_next;
        step_d = step_q + 1'b1;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
        first_d = first_next;
`endif
        if (step_q == SHIFT_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d  = cnt_next;
        step_d = step_q + 1'b1;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
        first_d = first_next;
`endif
        if (step_q == STEP_LAST) begin
          res_cnt_d = cnt_next;
          res_id_d  = id_q;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
          res_first_d = first_next;
`endif
          state_d   = REPORT;
        end
      end
      REPORT: begin
        rq.done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      ptr_q       <= '0;
      id_q        <= '0;
      res_id_q    <= '0;
      word_q      <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      res_cnt_q   <= '0;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
      first_q     <= '0;
      res_first_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      res_id_q    <= res_id_d;
      word_q      <= word_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      res_cnt_q   <= res_cnt_d;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
      first_q     <= first_d;
      res_first_q <= res_first_d;
`endif
    end
  end

  assign rq.done_id    = res_id_q;
  assign rq.done_count = res_cnt_q;
`ifdef SEQ_DET_SCHED_FIRSTHIT_EN
  assign rq.done_first = res_first_q;
`endif
endmodule
